mem_arbiter_mb: RTL

- Multi-bank shared-memory arbiter between NUM_CORES cores and NUM_BANKS internal single-port SRAM banks.
- Each bank arbitrates independently, round-robin, so accesses to distinct banks proceed in parallel in the same cycle.
- Successor to the single-grant arbiter: parametrised core/bank/width counts, per-bank fairness pointers, registered per-core response.

---
 rtl/mem_arbiter_mb.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_mb.sv
// Multi-bank shared-memory arbiter: NUM_CORES cores, NUM_BANKS single-port banks, per-bank round-robin.
// Define MEM_ARB_CONFLICT_CNT_EN to add per-bank saturating contention counters on conflict_cnt.
module mem_arbiter_mb #(
  parameter int NUM_CORES   = 16,
  parameter int NUM_BANKS   = 4,
  parameter int REG_SIZE    = 8,
  parameter int WORD_ADDR_W = 8,
  parameter int BANK_ID_W   = 2,
  parameter int ADDR_SIZE   = BANK_ID_W + WORD_ADDR_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2*NUM_CORES-1:0]        enable,
  input  logic [ADDR_SIZE*NUM_CORES-1:0] addr,
  input  logic [REG_SIZE*NUM_CORES-1:0] wr_data,
  output logic [REG_SIZE*NUM_CORES-1:0] rd_data,
  output logic [NUM_CORES-1:0]          ready
`ifdef MEM_ARB_CONFLICT_CNT_EN
  ,
  output logic [NUM_BANKS*16-1:0]       conflict_cnt
`endif
);

  localparam int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int DEPTH  = 1 << WORD_ADDR_W;
  localparam logic [CORE_W-1:0] LAST_CORE = CORE_W'(NUM_CORES - 1);

  // Handshake: a core presents {wr,rd}=01/10 with addr/wr_data and holds them
  // until it sees ready[c]; ready is a one-cycle pulse one clock after the grant,
  // and a request still asserted during that pulse is treated as a new request.

  logic [NUM_CORES-1:0]   req_valid;
  logic [NUM_CORES-1:0]   req_wr;
  logic [BANK_ID_W-1:0]   req_bank [NUM_CORES];
  logic [WORD_ADDR_W-1:0] req_word [NUM_CORES];

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      req_valid[c] = enable[2*c] ^ enable[2*c+1];
      req_wr[c]    = enable[2*c+1] & ~enable[2*c];
      req_bank[c]  = addr[c*ADDR_SIZE + ADDR_SIZE - BANK_ID_W +: BANK_ID_W];
      req_word[c]  = addr[c*ADDR_SIZE +: WORD_ADDR_W];
    end
  end

  logic [CORE_W-1:0]      ptr_q      [NUM_BANKS];
  logic [NUM_BANKS-1:0]   grant_valid;
  logic [NUM_BANKS-1:0]   grant_wr;
  logic [CORE_W-1:0]      grant_core [NUM_BANKS];
  logic [WORD_ADDR_W-1:0] grant_word [NUM_BANKS];
  logic [REG_SIZE-1:0]    grant_data [NUM_BANKS];
  logic [REG_SIZE-1:0]    bank_rdata [NUM_BANKS];
  logic [NUM_CORES-1:0]   core_grant;
  logic [REG_SIZE*NUM_CORES-1:0] rd_next;

  // Per-bank search from ptr+1 upward with wrap; first matching requester wins.
  always_comb begin
    int idx;
    core_grant = '0;
    idx        = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      grant_valid[b] = 1'b0;
      grant_wr[b]    = 1'b0;
      grant_core[b]  = '0;
      grant_word[b]  = '0;
      grant_data[b]  = '0;
      for (int k = 1; k <= NUM_CORES; k++) begin
        idx = int'(ptr_q[b]) + k;
        if (idx >= NUM_CORES) idx = idx - NUM_CORES;
        if (!grant_valid[b] && req_valid[idx] && req_bank[idx] == BANK_ID_W'(b)) begin
          grant_valid[b]  = 1'b1;
          grant_wr[b]     = req_wr[idx];
          grant_core[b]   = CORE_W'(idx);
          grant_word[b]   = req_word[idx];
          grant_data[b]   = wr_data[idx*REG_SIZE +: REG_SIZE];
          core_grant[idx] = 1'b1;
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [REG_SIZE-1:0] mem [DEPTH];

    // Writes are suppressed in the reset cycle; contents are never cleared.
    always_ff @(posedge clk) begin
      if (!reset && grant_valid[b] && grant_wr[b])
        mem[grant_word[b]] <= grant_data[b];
    end

    assign bank_rdata[b] = mem[grant_word[b]];
  end

  always_comb begin
    rd_next = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (grant_valid[b] && !grant_wr[b])
        rd_next[int'(grant_core[b])*REG_SIZE +: REG_SIZE] = bank_rdata[b];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready   <= '0;
      rd_data <= '0;
      for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= LAST_CORE;
    end else begin
      ready   <= core_grant;
      rd_data <= rd_next;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (grant_valid[b]) ptr_q[b] <= grant_core[b];
      end
    end
  end

`ifdef MEM_ARB_CONFLICT_CNT_EN
  logic [NUM_BANKS-1:0] bank_multi;
  logic [15:0]          conf_q [NUM_BANKS];

  always_comb begin
    int n;
    n = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      n = 0;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (req_valid[c] && req_bank[c] == BANK_ID_W'(b)) n = n + 1;
      end
      bank_multi[b] = (n >= 2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) conf_q[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank_multi[b] && conf_q[b] != 16'hFFFF) conf_q[b] <= conf_q[b] + 16'd1;
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) conflict_cnt[b*16 +: 16] = conf_q[b];
  end
`endif

endmodule
